// File: rtl/segment_capture_decoder_pkg.sv
// Shared definitions for the segment capture decoder.
//   SEG_PATTERNS    : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   DIGIT_INVALID   : digit code stored when a captured pattern is not a digit
//   state_e         : capture FSM state encoding
//   POS_*           : digit position indices (match anode bit numbers)
//   helper functions: anode legality, anode -> position, two-digit to binary
package segment_capture_decoder_pkg;

    localparam logic [6:0] SEG_PATTERNS [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_e;

    localparam logic [1:0] POS_SEC_ONES = 2'd0;
    localparam logic [1:0] POS_SEC_TENS = 2'd1;
    localparam logic [1:0] POS_MIN_ONES = 2'd2;
    localparam logic [1:0] POS_MIN_TENS = 2'd3;

    // Exactly one enable low; blank and multi-digit samples are rejected.
    function automatic logic anode_is_legal(input logic [3:0] anode);
        logic legal;
        case (anode)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [1:0] anode_pos(input logic [3:0] anode);
        logic [1:0] pos;
        case (anode)
            4'b1101: pos = POS_SEC_TENS;
            4'b1011: pos = POS_MIN_ONES;
            4'b0111: pos = POS_MIN_TENS;
            default: pos = POS_SEC_ONES;
        endcase
        return pos;
    endfunction

    // tens*10 + ones using shifts only; max 99 fits in 7 bits.
    function automatic logic [6:0] bcd_pair_to_bin(input logic [3:0] tens,
                                                   input logic [3:0] ones);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/segment_capture_decoder_seg_pattern_decoder.sv
// Combinational 7-segment pattern decoder.
//   pattern_i : active-low segment pattern {g,f,e,d,c,b,a}
//   valid_o   : pattern matches one of the ten digit patterns
//   digit_o   : decoded digit, DIGIT_INVALID when valid_o is low
module seg_pattern_decoder
    import segment_capture_decoder_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       valid_o,
    output logic [3:0] digit_o
);

    always_comb begin
        valid_o = 1'b0;
        digit_o = DIGIT_INVALID;
        for (int i = 0; i < 10; i++) begin
            if (pattern_i == SEG_PATTERNS[i]) begin
                valid_o = 1'b1;
                digit_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/segment_capture_decoder.sv
// Recovers MM:SS from a multiplexed, active-low 4-digit 7-segment display.
//   clock         : single clock, rising edge
//   reset         : synchronous active-low reset
//   anode_signals : active-low digit enables [3]=min tens .. [0]=sec ones
//   display_out   : active-low segments {g,f,e,d,c,b,a}
//   minutes       : binary minutes from the last good frame
//   seconds       : binary seconds from the last good frame
//   frame_valid   : one-cycle pulse per completed frame
//   digit_error   : last completed frame contained an undecodable digit
//
// state  | meaning
// IDLE   | no legal sample latched; waiting for exactly one anode low
// SETTLE | counting consecutive identical samples of the latched value
// HELD   | latched value captured; waiting for the sample to change
module segment_capture_decoder
    import segment_capture_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] anode_signals,
    input  logic [6:0] display_out,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic       frame_valid,
    output logic       digit_error
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [3:0] anode_s1_q, anode_s2_q;
    logic [6:0] seg_s1_q, seg_s2_q;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] lat_anode_q, lat_anode_d;
    logic [6:0] lat_seg_q, lat_seg_d;
    logic       capture;

    logic [3:0] digit_q [4];
    logic [3:0] valid_q;
    logic [3:0] mask_q;
    logic [6:0] minutes_q, seconds_q;
    logic       frame_valid_q, digit_error_q;

    logic       legal, same_sample, frame_done;
    logic       dec_valid;
    logic [3:0] dec_digit;
    logic [1:0] cap_pos;
    logic [3:0] cap_onehot;

    always_ff @(posedge clock) begin
        if (!reset) begin
            anode_s1_q <= 4'hF;
            anode_s2_q <= 4'hF;
            seg_s1_q   <= 7'h7F;
            seg_s2_q   <= 7'h7F;
        end else begin
            anode_s1_q <= anode_signals;
            anode_s2_q <= anode_s1_q;
            seg_s1_q   <= display_out;
            seg_s2_q   <= seg_s1_q;
        end
    end

    assign legal       = anode_is_legal(anode_s2_q);
    assign same_sample = (anode_s2_q == lat_anode_q) && (seg_s2_q == lat_seg_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_anode_d = lat_anode_q;
        lat_seg_d   = lat_seg_q;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (legal) begin
                    state_d     = ST_SETTLE;
                    cnt_d       = 8'd1;
                    lat_anode_d = anode_s2_q;
                    lat_seg_d   = seg_s2_q;
                end
            end
            ST_SETTLE: begin
                if (!legal) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (same_sample) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == STABLE_CNT) begin
                        capture = 1'b1;
                        state_d = ST_HELD;
                    end
                end else begin
                    cnt_d       = 8'd1;
                    lat_anode_d = anode_s2_q;
                    lat_seg_d   = seg_s2_q;
                end
            end
            ST_HELD: begin
                if (!same_sample) begin
                    if (legal) begin
                        state_d     = ST_SETTLE;
                        cnt_d       = 8'd1;
                        lat_anode_d = anode_s2_q;
                        lat_seg_d   = seg_s2_q;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            lat_anode_q <= 4'hF;
            lat_seg_q   <= 7'h7F;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_anode_q <= lat_anode_d;
            lat_seg_q   <= lat_seg_d;
        end
    end

    // On a capture edge the latched value equals the live sample, so the
    // registered copy is decoded.
    seg_pattern_decoder u_seg_pattern_decoder (
        .pattern_i (lat_seg_q),
        .valid_o   (dec_valid),
        .digit_o   (dec_digit)
    );

    assign cap_pos    = anode_pos(lat_anode_q);
    assign cap_onehot = 4'b0001 << cap_pos;
    assign frame_done = (mask_q == 4'hF);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 4'd0;
            end
            valid_q       <= 4'h0;
            mask_q        <= 4'h0;
            minutes_q     <= 7'd0;
            seconds_q     <= 7'd0;
            frame_valid_q <= 1'b0;
            digit_error_q <= 1'b0;
        end else begin
            frame_valid_q <= frame_done;
            // Clear first, then OR in a coincident capture so it counts
            // toward the next frame.
            mask_q <= (frame_done ? 4'h0 : mask_q) | (capture ? cap_onehot : 4'h0);
            if (capture) begin
                digit_q[cap_pos] <= dec_valid ? dec_digit : DIGIT_INVALID;
                valid_q[cap_pos] <= dec_valid;
            end
            if (frame_done) begin
                if (&valid_q) begin
                    minutes_q     <= bcd_pair_to_bin(digit_q[POS_MIN_TENS], digit_q[POS_MIN_ONES]);
                    seconds_q     <= bcd_pair_to_bin(digit_q[POS_SEC_TENS], digit_q[POS_SEC_ONES]);
                    digit_error_q <= 1'b0;
                end else begin
                    digit_error_q <= 1'b1;
                end
            end
        end
    end

    assign minutes     = minutes_q;
    assign seconds     = seconds_q;
    assign frame_valid = frame_valid_q;
    assign digit_error = digit_error_q;

endmodule
